// File: rtl/bus_select_pipe_if.sv
// Bus source selector interface: one-hot source enables and words in,
// registered bus word, winner index and conflict debug state out.
interface bus_select_pipe_if #(
  parameter int NUM_SRC = 24,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 5
);
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_en;
  logic                      hold;
  logic                      conflict_clr;
  logic [DATA_W-1:0]         bus_out;
  logic [SEL_W-1:0]          bus_sel;
  logic                      bus_valid;
  logic                      conflict;
  logic                      conflict_sticky;
  logic [NUM_SRC-1:0]        conflict_mask;

  // Control side: drives sources and controls, observes the bus.
  modport master (
    output src_data, src_en, hold, conflict_clr,
    input  bus_out, bus_sel, bus_valid, conflict, conflict_sticky, conflict_mask
  );

  // Selector side.
  modport slave (
    input  src_data, src_en, hold, conflict_clr,
    output bus_out, bus_sel, bus_valid, conflict, conflict_sticky, conflict_mask
  );
endinterface

// File: rtl/bus_select_pipe.sv
// Registered bus source selector. Encodes one-hot source enables (lowest
// index wins), registers the chosen word with one cycle of latency, and
// records multi-driver conflicts for debug.
module bus_select_pipe #(
  parameter int NUM_SRC    = 24,
  parameter int DATA_W     = 32,
  parameter int SEL_W      = 5,
  parameter bit HOLD_EMPTY = 1'b1
) (
  input logic             clk,
  input logic             clr_n,
  bus_select_pipe_if.slave bus
);

  // Reject parameter sets where the winner index cannot be represented.
  if ((NUM_SRC < 2) || (DATA_W < 1) || ((2 ** SEL_W) < NUM_SRC)) begin : gParamCheck
    $error("bus_select_pipe: illegal NUM_SRC/DATA_W/SEL_W combination");
  end

  logic [DATA_W-1:0] srcWord [NUM_SRC];
  logic              anyEn;
  logic              multiEn;
  logic [SEL_W-1:0]  winnerIdx;
  logic [DATA_W-1:0] winnerData;
  logic              conflictCond;

  logic [DATA_W-1:0]  busOutReg;
  logic [SEL_W-1:0]   busSelReg;
  logic               busValidReg;
  logic               conflictReg;
  logic               stickyReg;
  logic [NUM_SRC-1:0] maskReg;

  // Unflatten the source bus into one word per source.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : gSrcWord
    assign srcWord[gi] = bus.src_data[gi*DATA_W +: DATA_W];
  end

  // Priority encode the enables and detect a second active enable; only the
  // ">= 2" decision is needed, so a running "seen one already" flag suffices.
  always_comb begin
    anyEn      = 1'b0;
    multiEn    = 1'b0;
    winnerIdx  = '0;
    winnerData = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.src_en[i]) begin
        if (anyEn) begin
          multiEn = 1'b1;
        end else begin
          winnerIdx  = SEL_W'(i);
          winnerData = srcWord[i];
        end
        anyEn = 1'b1;
      end
    end
  end

  // A frozen bus never reports a conflict.
  assign conflictCond = multiEn & ~bus.hold;

  // Bus word, winner index and valid flag; frozen while hold is high.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      busOutReg   <= '0;
      busSelReg   <= '0;
      busValidReg <= 1'b0;
    end else if (!bus.hold) begin
      if (anyEn) begin
        busOutReg   <= winnerData;
        busSelReg   <= winnerIdx;
        busValidReg <= 1'b1;
      end else begin
        busSelReg   <= '0;
        busValidReg <= 1'b0;
        if (!HOLD_EMPTY) begin
          busOutReg <= '0;
        end
      end
    end
  end

  // Conflict pulse, sticky flag (set beats clear) and first-conflict snapshot.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      conflictReg <= 1'b0;
      stickyReg   <= 1'b0;
      maskReg     <= '0;
    end else begin
      conflictReg <= conflictCond;
      stickyReg   <= conflictCond | (stickyReg & ~bus.conflict_clr);
      if (conflictCond && (!stickyReg || bus.conflict_clr)) begin
        maskReg <= bus.src_en;
      end else if (bus.conflict_clr) begin
        maskReg <= '0;
      end
    end
  end

  assign bus.bus_out         = busOutReg;
  assign bus.bus_sel         = busSelReg;
  assign bus.bus_valid       = busValidReg;
  assign bus.conflict        = conflictReg;
  assign bus.conflict_sticky = stickyReg;
  assign bus.conflict_mask   = maskReg;

endmodule

// File: tb/tb_bus_select_pipe.sv
// Directed bench for bus_select_pipe: default configuration with both empty
// policies, plus a small 5-source configuration.
module tb_bus_select_pipe;

  logic clk;
  logic clr_n;
  int   assertCount = 0;
  int   failCount   = 0;

  bus_select_pipe_if #(.NUM_SRC(24), .DATA_W(32), .SEL_W(5)) ifA ();
  bus_select_pipe_if #(.NUM_SRC(24), .DATA_W(32), .SEL_W(5)) ifB ();
  bus_select_pipe_if #(.NUM_SRC(5),  .DATA_W(8),  .SEL_W(3)) ifC ();

  // Second default-size instance follows the first one's stimulus.
  assign ifB.src_data     = ifA.src_data;
  assign ifB.src_en       = ifA.src_en;
  assign ifB.hold         = ifA.hold;
  assign ifB.conflict_clr = ifA.conflict_clr;

  bus_select_pipe #(.NUM_SRC(24), .DATA_W(32), .SEL_W(5), .HOLD_EMPTY(1'b1)) dutA (
    .clk(clk), .clr_n(clr_n), .bus(ifA));
  bus_select_pipe #(.NUM_SRC(24), .DATA_W(32), .SEL_W(5), .HOLD_EMPTY(1'b0)) dutB (
    .clk(clk), .clr_n(clr_n), .bus(ifB));
  bus_select_pipe #(.NUM_SRC(5), .DATA_W(8), .SEL_W(3), .HOLD_EMPTY(1'b1)) dutC (
    .clk(clk), .clr_n(clr_n), .bus(ifC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setSrc(input int idx, input logic [31:0] w);
    ifA.src_data[idx*32 +: 32] = w;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    $display("%-10s en=%06h out=%08h sel=%0d valid=%b confl=%b sticky=%b mask=%06h | B out=%08h | C out=%02h sel=%0d",
             tag, ifA.src_en, ifA.bus_out, ifA.bus_sel, ifA.bus_valid, ifA.conflict,
             ifA.conflict_sticky, ifA.conflict_mask, ifB.bus_out, ifC.bus_out, ifC.bus_sel);
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    ifA.src_data = '0; ifA.src_en = '0; ifA.hold = 1'b0; ifA.conflict_clr = 1'b0;
    ifC.src_data = '0; ifC.src_en = '0; ifC.hold = 1'b0; ifC.conflict_clr = 1'b0;
    #12;
    clr_n = 1'b1;
    setSrc(0, 32'hDEADBEEF);
    ifA.src_en = 24'h000001;
    tick("preload");
    assertCount++;
    if (ifA.bus_out !== 32'hDEADBEEF) begin
      failCount++; $display("FAIL reset_preload: bus_out=%h expected=%h", ifA.bus_out, 32'hDEADBEEF);
    end
    #3;
    clr_n = 1'b0;
    #1;
    $display("async_rst  out=%08h sel=%0d valid=%b", ifA.bus_out, ifA.bus_sel, ifA.bus_valid);
    assertCount++;
    if (ifA.bus_out !== 32'h0) begin
      failCount++; $display("FAIL reset_async_out: bus_out=%h expected=0", ifA.bus_out);
    end
    assertCount++;
    if ({ifA.bus_sel, ifA.bus_valid, ifA.conflict, ifA.conflict_sticky} !== 8'h0) begin
      failCount++; $display("FAIL reset_async_ctl: sel=%0d valid=%b conflict=%b sticky=%b expected all 0",
                            ifA.bus_sel, ifA.bus_valid, ifA.conflict, ifA.conflict_sticky);
    end
    assertCount++;
    if (ifA.conflict_mask !== 24'h0) begin
      failCount++; $display("FAIL reset_async_mask: mask=%h expected=0", ifA.conflict_mask);
    end
    tick("in_reset");
    assertCount++;
    if (ifA.bus_out !== 32'h0 || ifA.bus_valid !== 1'b0) begin
      failCount++; $display("FAIL reset_held: bus_out=%h valid=%b expected 0/0", ifA.bus_out, ifA.bus_valid);
    end
    ifA.src_en = '0;
    #2;
    clr_n = 1'b1;
    tick("released");
    assertCount++;
    if (ifA.bus_valid !== 1'b0 || ifA.bus_out !== 32'h0) begin
      failCount++; $display("FAIL reset_release: valid=%b bus_out=%h expected 0/0", ifA.bus_valid, ifA.bus_out);
    end
  endtask

  task automatic test_one_hot();
    setSrc(20, 32'h00001234);
    ifA.src_en = 24'h1 << 20;
    tick("one_hot");
    assertCount++;
    if (ifA.bus_out !== 32'h00001234) begin
      failCount++; $display("FAIL one_hot_out: bus_out=%h expected=%h", ifA.bus_out, 32'h00001234);
    end
    assertCount++;
    if (ifA.bus_sel !== 5'd20) begin
      failCount++; $display("FAIL one_hot_sel: bus_sel=%0d expected=20", ifA.bus_sel);
    end
    assertCount++;
    if (ifA.bus_valid !== 1'b1 || ifA.conflict !== 1'b0) begin
      failCount++; $display("FAIL one_hot_flags: valid=%b conflict=%b expected 1/0", ifA.bus_valid, ifA.conflict);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] prevExp;
    logic [31:0] exp;
    prevExp = 32'h00001234;
    for (int i = 0; i < 24; i++) setSrc(i, i * 32'h01010101);
    for (int i = 0; i < 24; i++) begin
      exp = i * 32'h01010101;
      ifA.src_en = 24'h1 << i;
      #1;
      assertCount++;
      if (ifA.bus_out !== prevExp) begin
        failCount++; $display("FAIL sweep_pre_edge[%0d]: bus_out=%h expected=%h", i, ifA.bus_out, prevExp);
      end
      tick("sweep");
      assertCount++;
      if (ifA.bus_out !== exp) begin
        failCount++; $display("FAIL sweep_out[%0d]: bus_out=%h expected=%h", i, ifA.bus_out, exp);
      end
      assertCount++;
      if (ifA.bus_sel !== 5'(i) || ifA.bus_valid !== 1'b1) begin
        failCount++; $display("FAIL sweep_sel[%0d]: sel=%0d valid=%b expected %0d/1", i, ifA.bus_sel, ifA.bus_valid, i);
      end
      prevExp = exp;
    end
  endtask

  task automatic test_conflict();
    setSrc(3, 32'hAAAA0000);
    setSrc(7, 32'h77777777);
    ifA.src_en = 24'h000088;
    tick("confl_3_7");
    assertCount++;
    if (ifA.bus_out !== 32'hAAAA0000 || ifA.bus_sel !== 5'd3) begin
      failCount++; $display("FAIL conflict_winner: out=%h sel=%0d expected AAAA0000/3", ifA.bus_out, ifA.bus_sel);
    end
    assertCount++;
    if (ifA.conflict !== 1'b1 || ifA.conflict_sticky !== 1'b1) begin
      failCount++; $display("FAIL conflict_flags: conflict=%b sticky=%b expected 1/1", ifA.conflict, ifA.conflict_sticky);
    end
    assertCount++;
    if (ifA.conflict_mask !== 24'h000088) begin
      failCount++; $display("FAIL conflict_mask_first: mask=%h expected=000088", ifA.conflict_mask);
    end
    ifA.src_en = 24'h000006;
    tick("confl_1_2");
    assertCount++;
    if (ifA.conflict !== 1'b1 || ifA.bus_sel !== 5'd1) begin
      failCount++; $display("FAIL conflict_b2b: conflict=%b sel=%0d expected 1/1", ifA.conflict, ifA.bus_sel);
    end
    assertCount++;
    if (ifA.conflict_mask !== 24'h000088) begin
      failCount++; $display("FAIL conflict_mask_kept: mask=%h expected=000088", ifA.conflict_mask);
    end
    ifA.src_en = 24'h1 << 5;
    ifA.conflict_clr = 1'b1;
    tick("clr_only");
    assertCount++;
    if (ifA.conflict !== 1'b0 || ifA.conflict_sticky !== 1'b0 || ifA.conflict_mask !== 24'h0) begin
      failCount++; $display("FAIL conflict_clear: conflict=%b sticky=%b mask=%h expected 0/0/0",
                            ifA.conflict, ifA.conflict_sticky, ifA.conflict_mask);
    end
    ifA.conflict_clr = 1'b0;
    ifA.src_en = 24'h000011;
    tick("confl_0_4");
    assertCount++;
    if (ifA.conflict_sticky !== 1'b1 || ifA.conflict_mask !== 24'h000011) begin
      failCount++; $display("FAIL conflict_recapture: sticky=%b mask=%h expected 1/000011",
                            ifA.conflict_sticky, ifA.conflict_mask);
    end
    ifA.src_en = 24'h000204;
    ifA.conflict_clr = 1'b1;
    tick("clr+confl");
    assertCount++;
    if (ifA.conflict_sticky !== 1'b1 || ifA.conflict !== 1'b1) begin
      failCount++; $display("FAIL conflict_set_wins: sticky=%b conflict=%b expected 1/1", ifA.conflict_sticky, ifA.conflict);
    end
    assertCount++;
    if (ifA.conflict_mask !== 24'h000204) begin
      failCount++; $display("FAIL conflict_clr_reload: mask=%h expected=000204", ifA.conflict_mask);
    end
    ifA.conflict_clr = 1'b0;
    ifA.hold = 1'b1;
    ifA.src_en = 24'h000003;
    tick("hold_confl");
    assertCount++;
    if (ifA.conflict !== 1'b0 || ifA.conflict_mask !== 24'h000204) begin
      failCount++; $display("FAIL conflict_under_hold: conflict=%b mask=%h expected 0/000204", ifA.conflict, ifA.conflict_mask);
    end
    ifA.hold = 1'b0;
    ifA.src_en = '0;
    ifA.conflict_clr = 1'b1;
    tick("clr_idle");
    ifA.conflict_clr = 1'b0;
    assertCount++;
    if (ifA.conflict_sticky !== 1'b0) begin
      failCount++; $display("FAIL conflict_final_clear: sticky=%b expected 0", ifA.conflict_sticky);
    end
  endtask

  task automatic test_hold_empty();
    setSrc(6, 32'h00000005);
    ifA.src_en = 24'h1 << 6;
    tick("load_5");
    assertCount++;
    if (ifA.bus_out !== 32'h5 || ifB.bus_out !== 32'h5) begin
      failCount++; $display("FAIL hold_load: A=%h B=%h expected 5/5", ifA.bus_out, ifB.bus_out);
    end
    setSrc(0, 32'h00000009);
    ifA.src_en = 24'h000001;
    ifA.hold = 1'b1;
    tick("hold");
    assertCount++;
    if (ifA.bus_out !== 32'h5 || ifA.bus_sel !== 5'd6 || ifA.bus_valid !== 1'b1) begin
      failCount++; $display("FAIL hold_frozen: out=%h sel=%0d valid=%b expected 5/6/1", ifA.bus_out, ifA.bus_sel, ifA.bus_valid);
    end
    ifA.hold = 1'b0;
    ifA.src_en = '0;
    tick("empty");
    assertCount++;
    if (ifA.bus_out !== 32'h5 || ifA.bus_valid !== 1'b0 || ifA.bus_sel !== 5'd0) begin
      failCount++; $display("FAIL empty_keep: out=%h valid=%b sel=%0d expected 5/0/0", ifA.bus_out, ifA.bus_valid, ifA.bus_sel);
    end
    assertCount++;
    if (ifB.bus_out !== 32'h0 || ifB.bus_valid !== 1'b0) begin
      failCount++; $display("FAIL empty_zero: out=%h valid=%b expected 0/0", ifB.bus_out, ifB.bus_valid);
    end
  endtask

  task automatic test_param();
    ifC.src_data[4*8 +: 8] = 8'hC3;
    ifC.src_en = 5'b10000;
    tick("param_4");
    assertCount++;
    if (ifC.bus_out !== 8'hC3 || ifC.bus_sel !== 3'd4 || ifC.bus_valid !== 1'b1) begin
      failCount++; $display("FAIL param_select: out=%h sel=%0d valid=%b expected C3/4/1", ifC.bus_out, ifC.bus_sel, ifC.bus_valid);
    end
    ifC.src_data[1*8 +: 8] = 8'h5A;
    ifC.src_en = 5'b10010;
    tick("param_cf");
    assertCount++;
    if (ifC.bus_out !== 8'h5A || ifC.bus_sel !== 3'd1 || ifC.conflict !== 1'b1) begin
      failCount++; $display("FAIL param_conflict: out=%h sel=%0d conflict=%b expected 5A/1/1", ifC.bus_out, ifC.bus_sel, ifC.conflict);
    end
    assertCount++;
    if (ifC.conflict_mask !== 5'b10010) begin
      failCount++; $display("FAIL param_mask: mask=%b expected=10010", ifC.conflict_mask);
    end
  endtask

  initial begin
    test_reset();
    test_one_hot();
    test_sweep();
    test_conflict();
    test_hold_empty();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
